// File: rtl/sid_regs_pkg.sv
// Shared definitions for the SID Voice-1 register scheduler:
// register map, valid-address mask and commit FSM states.
package sid_regs_pkg;

  localparam logic [2:0] REG_FLO = 3'd0;
  localparam logic [2:0] REG_FHI = 3'd1;
  localparam logic [2:0] REG_PW  = 3'd2;
  localparam logic [2:0] REG_ATK = 3'd4;
  localparam logic [2:0] REG_SUS = 3'd5;
  localparam logic [2:0] REG_WAV = 3'd6;

  // Bit n set = address n maps to a real register; 3 and 7 are holes.
  localparam logic [7:0] REG_VALID = 8'b0111_0111;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    DIRTY = 2'd1,
    HELD  = 2'd2
  } commit_state_t;

endpackage

// File: rtl/sid_wr_arb.sv
// Two-way write arbiter between the host and sequencer ports.
// Build option SID_SCHED_RR_EN: round-robin on contention (last-grant
// state kept, HOST_PRIO ignored); otherwise fixed priority per HOST_PRIO.
module sid_wr_arb #(
  parameter bit HOST_PRIO = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic h_valid,
  input  logic s_valid,
  output logic h_grant,
  output logic s_grant
);

`ifdef SID_SCHED_RR_EN
  logic last_host;

  // Remember which port won the most recent transfer; reset favours host next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_host <= 1'b0;
    end else if (h_grant) begin
      last_host <= 1'b1;
    end else if (s_grant) begin
      last_host <= 1'b0;
    end
  end

  // On contention the port that did not win last time is granted.
  always_comb begin
    h_grant = h_valid && (!s_valid || !last_host);
    s_grant = s_valid && !h_grant;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  // Fixed priority on contention, selected by HOST_PRIO.
  always_comb begin
    h_grant = h_valid && (!s_valid || HOST_PRIO);
    s_grant = s_valid && !h_grant;
  end
`endif

endmodule

// File: rtl/sid_reg_sched.sv
// SID Voice-1 register write scheduler: arbitrates host/sequencer byte
// writes into a shadow bank and commits the whole bank to the live outputs
// on an eligible frame_tick. Build option SID_SCHED_RR_EN selects
// round-robin arbitration in sid_wr_arb.
module sid_reg_sched
  import sid_regs_pkg::*;
#(
  parameter bit HOST_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        commit_hold,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [2:0]  h_addr,
  input  logic [7:0]  h_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [2:0]  s_addr,
  input  logic [7:0]  s_data,
  output logic [15:0] sid_frequency,
  output logic [7:0]  sid_duration,
  output logic [7:0]  sid_attack,
  output logic [7:0]  sid_sustain,
  output logic [7:0]  sid_waveform,
  output logic        commit_pulse,
  output logic        pending
);

  logic          h_grant, s_grant;
  logic          wr_en, wr_hit;
  logic [2:0]    wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    sh_flo, sh_fhi, sh_pw, sh_atk, sh_sus, sh_wav;
  commit_state_t state;

  sid_wr_arb #(
    .HOST_PRIO (HOST_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .h_valid (h_valid),
    .s_valid (s_valid),
    .h_grant (h_grant),
    .s_grant (s_grant)
  );

  assign h_ready = h_grant;
  assign s_ready = s_grant;
  assign pending = (state != CLEAN);

  // Select the single accepted write of this cycle.
  always_comb begin
    wr_en   = h_grant || s_grant;
    wr_addr = h_grant ? h_addr : s_addr;
    wr_data = h_grant ? h_data : s_data;
    wr_hit  = wr_en && REG_VALID[wr_addr];
  end

  // Shadow bank: accepted writes land here; hole addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_flo <= '0;
      sh_fhi <= '0;
      sh_pw  <= '0;
      sh_atk <= '0;
      sh_sus <= '0;
      sh_wav <= '0;
    end else if (wr_en) begin
      unique case (wr_addr)
        REG_FLO: sh_flo <= wr_data;
        REG_FHI: sh_fhi <= wr_data;
        REG_PW:  sh_pw  <= wr_data;
        REG_ATK: sh_atk <= wr_data;
        REG_SUS: sh_sus <= wr_data;
        REG_WAV: sh_wav <= wr_data;
        default: ;
      endcase
    end
  end

  // Commit FSM with registered live outputs; a write coinciding with a
  // commit sees the pre-write shadow copied and keeps the FSM dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= CLEAN;
      sid_frequency <= '0;
      sid_duration  <= '0;
      sid_attack    <= '0;
      sid_sustain   <= '0;
      sid_waveform  <= '0;
      commit_pulse  <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      unique case (state)
        CLEAN: begin
          if (wr_hit) state <= DIRTY;
        end
        DIRTY: begin
          if (commit_hold) begin
            state <= HELD;
          end else if (frame_tick) begin
            sid_frequency <= {sh_fhi, sh_flo};
            sid_duration  <= sh_pw;
            sid_attack    <= sh_atk;
            sid_sustain   <= sh_sus;
            sid_waveform  <= sh_wav;
            commit_pulse  <= 1'b1;
            state         <= wr_hit ? DIRTY : CLEAN;
          end
        end
        HELD: begin
          if (!commit_hold) state <= DIRTY;
        end
        default: state <= CLEAN;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_reg_sched.sv
// Self-checking bench for sid_reg_sched: a register-bank model compared
// every cycle, plus directed scenarios with literal expectations.
// Honours SID_SCHED_RR_EN for the arbitration expectations.
module tb_sid_reg_sched;

  localparam bit HOST_PRIO = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0, commit_hold = 1'b0;
  logic        h_valid = 1'b0, s_valid = 1'b0;
  logic [2:0]  h_addr = '0, s_addr = '0;
  logic [7:0]  h_data = '0, s_data = '0;
  logic        h_ready, s_ready, commit_pulse, pending;
  logic [15:0] sid_frequency;
  logic [7:0]  sid_duration, sid_attack, sid_sustain, sid_waveform;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  sid_reg_sched #(.HOST_PRIO(HOST_PRIO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .commit_hold(commit_hold),
    .h_valid(h_valid), .h_ready(h_ready), .h_addr(h_addr), .h_data(h_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
    .sid_frequency(sid_frequency), .sid_duration(sid_duration),
    .sid_attack(sid_attack), .sid_sustain(sid_sustain), .sid_waveform(sid_waveform),
    .commit_pulse(commit_pulse), .pending(pending)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  bit [7:0] m_shadow [8];
  bit [7:0] m_live   [8];
  bit       m_dirty, m_held, m_pulse, m_last_host;

  function automatic bit exp_h_grant();
    if (h_valid && s_valid) begin
`ifdef SID_SCHED_RR_EN
      return !m_last_host;
`else
      return HOST_PRIO;
`endif
    end
    return h_valid;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = 8'h00;
        m_live[i]   = 8'h00;
      end
      m_dirty = 0; m_held = 0; m_pulse = 0; m_last_host = 0;
    end else begin
      bit hg, sg, commit, wrote;
      int a;
      hg = exp_h_grant();
      sg = s_valid && !hg;
      commit = m_dirty && !m_held && frame_tick && !commit_hold;
      m_pulse = commit;
      if (commit) m_live = m_shadow;
      wrote = 0;
      if (hg || sg) begin
        a = hg ? int'(h_addr) : int'(s_addr);
        if (a != 3 && a != 7) begin
          m_shadow[a] = hg ? h_data : s_data;
          wrote = 1;
        end
        m_last_host = hg;
      end
      m_held  = m_dirty && commit_hold;
      m_dirty = (m_dirty && !commit) || wrote;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("h_ready", {31'd0, h_ready}, {31'd0, exp_h_grant()});
      chk("s_ready", {31'd0, s_ready}, {31'd0, s_valid && !exp_h_grant()});
      chk("frequency", {16'd0, sid_frequency}, {16'd0, m_live[1], m_live[0]});
      chk("duration", {24'd0, sid_duration}, {24'd0, m_live[2]});
      chk("attack", {24'd0, sid_attack}, {24'd0, m_live[4]});
      chk("sustain", {24'd0, sid_sustain}, {24'd0, m_live[5]});
      chk("waveform", {24'd0, sid_waveform}, {24'd0, m_live[6]});
      chk("commit_pulse", {31'd0, commit_pulse}, {31'd0, m_pulse});
      chk("pending", {31'd0, pending}, {31'd0, m_dirty});
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic host(input logic v, input logic [2:0] a, input logic [7:0] d);
    h_valid = v; h_addr = a; h_data = d;
  endtask

  task automatic seq(input logic v, input logic [2:0] a, input logic [7:0] d);
    s_valid = v; s_addr = a; s_data = d;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    next();
    frame_tick = 1'b0;
  endtask

`ifdef SID_SCHED_RR_EN
  localparam logic [3:0] T3_PATTERN = 4'b0101;
  localparam logic [7:0] OLD_WAV    = 8'h23;
`else
  localparam logic [3:0] T3_PATTERN = 4'b1111;
  localparam logic [7:0] OLD_WAV    = 8'h00;
`endif

  initial begin
    logic [3:0] pat;
    logic hacc, sacc;
    int n;

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    started = 1'b1;
    @(negedge clk);
    chk("rst_freq", {16'd0, sid_frequency}, 32'h0);
    chk("rst_pending", {31'd0, pending}, 32'h0);
    chk("rst_pulse", {31'd0, commit_pulse}, 32'h0);
    next();

    // 1: two host writes build the frequency, one tick commits both bytes
    host(1, 3'd0, 8'h34);
    @(negedge clk);
    chk("t1_h_ready", {31'd0, h_ready}, 32'h1);
    next();
    host(1, 3'd1, 8'h12);
    next();
    host(0, 3'd0, 8'h00);
    frame_tick = 1'b1;
    @(negedge clk);
    chk("t1_pend_pre", {31'd0, pending}, 32'h1);
    chk("t1_freq_pre", {16'd0, sid_frequency}, 32'h0);
    next();
    frame_tick = 1'b0;
    @(negedge clk);
    chk("t1_freq", {16'd0, sid_frequency}, 32'h1234);
    chk("t1_pulse", {31'd0, commit_pulse}, 32'h1);
    chk("t1_pend", {31'd0, pending}, 32'h0);
    next();
    @(negedge clk);
    chk("t1_pulse_once", {31'd0, commit_pulse}, 32'h0);
    next();

    // 2: contention; loser holds its request until accepted
    host(1, 3'd2, 8'h56);
    seq(1, 3'd4, 8'h78);
    n = 0;
    while ((h_valid || s_valid) && n < 4) begin
      @(negedge clk);
      if (n == 0) begin
`ifdef SID_SCHED_RR_EN
        chk("t2_h_ready", {31'd0, h_ready}, 32'h0);
        chk("t2_s_ready", {31'd0, s_ready}, 32'h1);
`else
        chk("t2_h_ready", {31'd0, h_ready}, 32'h1);
        chk("t2_s_ready", {31'd0, s_ready}, 32'h0);
`endif
      end
      hacc = h_ready;
      sacc = s_ready;
      next();
      if (hacc) h_valid = 1'b0;
      if (sacc) s_valid = 1'b0;
      n++;
    end
    chk("t2_both_accepted", {30'd0, h_valid, s_valid}, 32'h0);
    chk("t2_cycles", n, 2);
    tick();
    @(negedge clk);
    chk("t2_duration", {24'd0, sid_duration}, 32'h56);
    chk("t2_attack", {24'd0, sid_attack}, 32'h78);
    next();

    // 3: both held valid for four cycles; record host grants
    host(1, 3'd5, 8'h9A);
    seq(1, 3'd6, 8'h23);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat[3-k] = h_ready;
      next();
    end
    host(0, 3'd0, 8'h00);
    seq(0, 3'd0, 8'h00);
    chk("t3_grant_pattern", {28'd0, pat}, {28'd0, T3_PATTERN});
    tick();
    @(negedge clk);
    chk("t3_sustain", {24'd0, sid_sustain}, 32'h9A);
    next();

    // 4: commit_hold defers; release coinciding with a tick is not eligible
    commit_hold = 1'b1;
    host(1, 3'd6, 8'h41);
    next();
    host(0, 3'd0, 8'h00);
    next();
    tick();
    @(negedge clk);
    chk("t4_wav_held", {24'd0, sid_waveform}, {24'd0, OLD_WAV});
    chk("t4_pend_held", {31'd0, pending}, 32'h1);
    chk("t4_pulse_held", {31'd0, commit_pulse}, 32'h0);
    next();
    commit_hold = 1'b0;
    tick();
    @(negedge clk);
    chk("t4_wav_release", {24'd0, sid_waveform}, {24'd0, OLD_WAV});
    chk("t4_pulse_release", {31'd0, commit_pulse}, 32'h0);
    next();
    tick();
    @(negedge clk);
    chk("t4_wav", {24'd0, sid_waveform}, 32'h41);
    chk("t4_pulse", {31'd0, commit_pulse}, 32'h1);
    next();

    // 5: write in the tick cycle from CLEAN, then from DIRTY
    host(1, 3'd2, 8'hAA);
    frame_tick = 1'b1;
    next();
    host(0, 3'd0, 8'h00);
    frame_tick = 1'b0;
    @(negedge clk);
    chk("t5_dur_same", {24'd0, sid_duration}, 32'h56);
    chk("t5_pulse_same", {31'd0, commit_pulse}, 32'h0);
    chk("t5_pend_same", {31'd0, pending}, 32'h1);
    next();
    tick();
    @(negedge clk);
    chk("t5_dur", {24'd0, sid_duration}, 32'hAA);
    next();
    host(1, 3'd4, 8'h11);
    next();
    host(1, 3'd5, 8'h22);
    frame_tick = 1'b1;
    next();
    host(0, 3'd0, 8'h00);
    frame_tick = 1'b0;
    @(negedge clk);
    chk("t5b_attack", {24'd0, sid_attack}, 32'h11);
    chk("t5b_sus_old", {24'd0, sid_sustain}, 32'h9A);
    chk("t5b_pend", {31'd0, pending}, 32'h1);
    next();
    tick();
    @(negedge clk);
    chk("t5b_sus", {24'd0, sid_sustain}, 32'h22);
    next();

    // 6: hole addresses leave the bank clean
    host(1, 3'd3, 8'hFF);
    next();
    host(1, 3'd7, 8'hEE);
    next();
    host(0, 3'd0, 8'h00);
    frame_tick = 1'b1;
    @(negedge clk);
    chk("t6_pend_hole", {31'd0, pending}, 32'h0);
    next();
    frame_tick = 1'b0;
    @(negedge clk);
    chk("t6_pulse_hole", {31'd0, commit_pulse}, 32'h0);
    next();

    // 6b: asynchronous reset while dirty with writes in flight
    host(1, 3'd0, 8'h77);
    next();
    host(1, 3'd1, 8'h66);
    seq(1, 3'd2, 8'h55);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_freq", {16'd0, sid_frequency}, 32'h0);
    chk("t6_rst_dur", {24'd0, sid_duration}, 32'h0);
    chk("t6_rst_atk", {24'd0, sid_attack}, 32'h0);
    chk("t6_rst_sus", {24'd0, sid_sustain}, 32'h0);
    chk("t6_rst_wav", {24'd0, sid_waveform}, 32'h0);
    chk("t6_rst_pend", {31'd0, pending}, 32'h0);
    host(0, 3'd0, 8'h00);
    seq(0, 3'd0, 8'h00);
    next();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_post_freq", {16'd0, sid_frequency}, 32'h0);
    chk("t6_post_pend", {31'd0, pending}, 32'h0);
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
